// File: rtl/counter_pkg.sv
// Shared definitions for the mod-N counter cascade.
//   clog2      : ceiling log2, used to size one digit
//   CNT_UP/DN  : direction encodings for the up_dn input
//   *_MIN/MAX  : legal ranges for the MOD and DIGITS parameters
package counter_pkg;

  localparam logic CNT_UP   = 1'b1;
  localparam logic CNT_DOWN = 1'b0;

  localparam int MOD_MIN    = 2;
  localparam int MOD_MAX    = 16;
  localparam int DIGITS_MIN = 1;
  localparam int DIGITS_MAX = 8;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(v)) r = int'(i) + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/modn_digit.sv
// One mod-MOD digit of the cascade.
//   clk, rst   : clock, synchronous active-high reset (digit -> 0)
//   step_in    : advance one count in the direction given by up_dn
//   up_dn      : 1 = up, 0 = down
//   load       : parallel load (priority over step_in)
//   load_val   : value to load; values >= MOD saturate to MOD-1
//   q          : current digit value
//   at_max     : q == MOD-1
//   at_min     : q == 0
module modn_digit
  import counter_pkg::*;
#(
  parameter int MOD = 10,
  parameter int W   = clog2(MOD)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         step_in,
  input  logic         up_dn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] q,
  output logic         at_max,
  output logic         at_min
);

  localparam logic [W-1:0] MAX_V = W'(MOD - 1);
  // One bit wider so MOD=16 is representable in the range compare.
  localparam logic [W:0]   MOD_V = (W+1)'(MOD);

  logic [W-1:0] q_q, q_d;
  logic [W-1:0] load_sat;
  logic [W-1:0] step_v;

  always_comb begin
    load_sat = load_val;
    if ({1'b0, load_val} >= MOD_V) load_sat = MAX_V;
  end

  // An out-of-range value returns to 0 on its next step in either direction.
  always_comb begin
    step_v = '0;
    if ({1'b0, q_q} >= MOD_V) begin
      step_v = '0;
    end else if (up_dn == CNT_UP) begin
      step_v = (q_q == MAX_V) ? '0 : q_q + 1'b1;
    end else begin
      step_v = (q_q == '0) ? MAX_V : q_q - 1'b1;
    end
  end

  always_comb begin
    q_d = q_q;
    if (load)         q_d = load_sat;
    else if (step_in) q_d = step_v;
  end

  always_ff @(posedge clk) begin
    if (rst) q_q <= '0;
    else     q_q <= q_d;
  end

  assign q      = q_q;
  assign at_max = (q_q == MAX_V);
  assign at_min = (q_q == '0);

endmodule

// File: rtl/modn_counter_cascade.sv
// Cascade of DIGITS mod-MOD digits sharing one clock, with a combinational
// ripple-enable chain (no derived clocks).
//   clk, rst   : clock, synchronous active-high reset
//   en         : count enable, one step per cycle
//   up_dn      : 1 = up, 0 = down
//   load       : parallel load strobe (priority over en)
//   load_val   : load value, digit i at [i*W +: W]
//   q          : registered count, same packing as load_val
//   tc         : terminal count (all MOD-1 going up, all 0 going down)
//   wrap       : registered one-cycle pulse after the whole chain wraps
module modn_counter_cascade
  import counter_pkg::*;
#(
  parameter  int MOD    = 10,
  parameter  int DIGITS = 4,
  localparam int W      = clog2(MOD)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                up_dn,
  input  logic                load,
  input  logic [DIGITS*W-1:0] load_val,
  output logic [DIGITS*W-1:0] q,
  output logic                tc,
  output logic                wrap
);

  if (MOD < MOD_MIN || MOD > MOD_MAX) begin : g_bad_mod
    $error("modn_counter_cascade: MOD=%0d outside %0d..%0d", MOD, MOD_MIN, MOD_MAX);
  end
  if (DIGITS < DIGITS_MIN || DIGITS > DIGITS_MAX) begin : g_bad_digits
    $error("modn_counter_cascade: DIGITS=%0d outside %0d..%0d", DIGITS, DIGITS_MIN, DIGITS_MAX);
  end

  logic [DIGITS-1:0] at_max, at_min;
  logic [DIGITS-1:0] step_c;
  logic              wrap_q, wrap_d;

  // Digit i steps when en is high and every lower digit sits at its
  // carry/borrow boundary for the current direction.
  always_comb begin
    step_c    = '0;
    step_c[0] = en;
    for (int unsigned i = 1; i < DIGITS; i++) begin
      step_c[i] = step_c[i-1] & ((up_dn == CNT_UP) ? at_max[i-1] : at_min[i-1]);
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    modn_digit #(
      .MOD (MOD),
      .W   (W)
    ) u_digit (
      .clk      (clk),
      .rst      (rst),
      .step_in  (step_c[g]),
      .up_dn    (up_dn),
      .load     (load),
      .load_val (load_val[g*W +: W]),
      .q        (q[g*W +: W]),
      .at_max   (at_max[g]),
      .at_min   (at_min[g])
    );
  end

  assign tc = (up_dn == CNT_UP) ? (&at_max) : (&at_min);

  always_comb begin
    wrap_d = en & tc & ~load;
  end

  always_ff @(posedge clk) begin
    if (rst) wrap_q <= 1'b0;
    else     wrap_q <= wrap_d;
  end

  assign wrap = wrap_q;

endmodule

// File: tb/tb_modn_counter_cascade.sv
module tb_modn_counter_cascade;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Decimal two-digit instance (modulus 10)
  logic       rst_a, en_a, up_a, load_a;
  logic [7:0] lv_a, q_a;
  logic       tc_a, wrap_a;

  // Base-6 three-digit instance (W=3)
  logic       rst_b, en_b, up_b, load_b;
  logic [8:0] lv_b, q_b;
  logic       tc_b, wrap_b;

  modn_counter_cascade #(.MOD(10), .DIGITS(2)) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .up_dn(up_a), .load(load_a),
    .load_val(lv_a), .q(q_a), .tc(tc_a), .wrap(wrap_a)
  );

  modn_counter_cascade #(.MOD(6), .DIGITS(3)) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .up_dn(up_b), .load(load_b),
    .load_val(lv_b), .q(q_b), .tc(tc_b), .wrap(wrap_b)
  );

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       rst;
    logic       load;
    logic       en;
    logic       up;
    logic [7:0] lv;
    logic [7:0] q;
    logic       wrap;
    logic       tc;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic l, logic e, logic u, logic [7:0] lv,
                              logic [7:0] q, logic w, logic t);
    vec_t v;
    v.rst = r; v.load = l; v.en = e; v.up = u; v.lv = lv;
    v.q = q; v.wrap = w; v.tc = t;
    return v;
  endfunction

  initial begin
    rst_a = 1'b1; en_a = 1'b0; up_a = 1'b1; load_a = 1'b0; lv_a = '0;
    rst_b = 1'b1; en_b = 1'b0; up_b = 1'b1; load_b = 1'b0; lv_b = '0;

    //            rst  ld   en   up   load_val  q      wrap tc
    vecs.push_back(mk(1, 0, 0, 1, 8'h00, 8'h00, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 8'h47, 8'h47, 0, 0));  // load beats en
    vecs.push_back(mk(0, 1, 1, 1, 8'hC3, 8'h93, 0, 0));  // upper digit saturates
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h94, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h09, 8'h09, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h10, 0, 0));  // carry into digit 1
    vecs.push_back(mk(0, 1, 0, 1, 8'hAF, 8'h99, 0, 1));  // both digits saturate
    vecs.push_back(mk(0, 0, 0, 1, 8'h00, 8'h99, 0, 1));  // tc with en=0, no wrap
    vecs.push_back(mk(0, 1, 1, 1, 8'h99, 8'h99, 0, 1));  // load at tc: no wrap
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h00, 1, 0));  // up wrap
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h01, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 8'h63, 8'h63, 0, 0));
    vecs.push_back(mk(1, 1, 1, 1, 8'h12, 8'h00, 0, 0));  // rst beats load+en
    vecs.push_back(mk(0, 0, 1, 1, 8'h00, 8'h01, 0, 0));  // resumes at 01
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h00, 0, 1));  // down to 00, tc
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h99, 1, 0));  // down wrap
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h98, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h97, 0, 0));
    vecs.push_back(mk(0, 1, 0, 1, 8'h50, 8'h50, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 8'h00, 8'h49, 0, 0));  // direction flip at 50
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0, 0, 0, 0, 8'h00, 8'h49, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 8'h00, 8'h00, 0, 1));  // reset with up_dn=0

    tick();
    for (int i = 0; i < vecs.size(); i++) begin
      rst_a = vecs[i].rst; load_a = vecs[i].load; en_a = vecs[i].en;
      up_a = vecs[i].up; lv_a = vecs[i].lv;
      tick();
      chk($sformatf("vec%0d.q", i),    32'(q_a),    32'(vecs[i].q));
      chk($sformatf("vec%0d.wrap", i), 32'(wrap_a), 32'(vecs[i].wrap));
      chk($sformatf("vec%0d.tc", i),   32'(tc_a),   32'(vecs[i].tc));
    end

    // Full up-count 00..99..00 from reset.
    rst_a = 1'b1; load_a = 1'b0; en_a = 1'b0; up_a = 1'b1;
    tick();
    chk("run.reset_q", 32'(q_a), 32'h0);
    chk("run.reset_tc", 32'(tc_a), 32'h0);
    rst_a = 1'b0; en_a = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      int c;
      logic [7:0] e;
      c = k % 100;
      e = {4'(c / 10), 4'(c % 10)};
      tick();
      chk($sformatf("run%0d.q", k),    32'(q_a),    32'(e));
      chk($sformatf("run%0d.tc", k),   32'(tc_a),   32'(c == 99));
      chk($sformatf("run%0d.wrap", k), 32'(wrap_a), 32'(c == 0));
    end
    en_a = 1'b0;

    // Base-6 instance: digits packed 3 bits each, digit 2 in [8:6].
    rst_b = 1'b1;
    tick();
    chk("m6.reset_q", 32'(q_b), 32'h0);
    rst_b = 1'b0; load_b = 1'b1; lv_b = {3'd0, 3'd5, 3'd5};
    tick();
    chk("m6.load055", 32'(q_b), 32'({3'd0, 3'd5, 3'd5}));
    load_b = 1'b0; en_b = 1'b1; up_b = 1'b1;
    tick();
    chk("m6.step100", 32'(q_b), 32'({3'd1, 3'd0, 3'd0}));
    chk("m6.step100_wrap", 32'(wrap_b), 32'h0);
    load_b = 1'b1; en_b = 1'b0; lv_b = {3'd5, 3'd5, 3'd5};
    tick();
    chk("m6.load555", 32'(q_b), 32'({3'd5, 3'd5, 3'd5}));
    chk("m6.tc555", 32'(tc_b), 32'h1);
    load_b = 1'b0; en_b = 1'b1;
    tick();
    chk("m6.wrap000_q", 32'(q_b), 32'h0);
    chk("m6.wrap000_w", 32'(wrap_b), 32'h1);
    up_b = 1'b0;
    #1;
    chk("m6.tc_down000", 32'(tc_b), 32'h1);
    tick();
    chk("m6.down555_q", 32'(q_b), 32'({3'd5, 3'd5, 3'd5}));
    chk("m6.down555_w", 32'(wrap_b), 32'h1);
    load_b = 1'b1; en_b = 1'b1; lv_b = {3'd7, 3'd2, 3'd6};
    tick();
    chk("m6.load_sat", 32'(q_b), 32'({3'd5, 3'd2, 3'd5}));
    chk("m6.load_sat_w", 32'(wrap_b), 32'h0);
    en_b = 1'b0; load_b = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
